// File: rtl/instr_encoder.sv
// RV32I instruction encoder: assembles decoded fields into instruction words tagged with IMEM addresses.
// Optional macro IMM_RANGE_CHECK_EN flags immediates that do not fit their format as illegal.
module instr_encoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [4:0]        opcode_i,
   input  logic [3:0]        alu_op_i,
   input  logic [2:0]        mem_funct3_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [4:0]        rd_i,
   input  logic [31:0]       imm_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              illegal_o,
   output logic              err_sticky_o
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_REG   = 5'b01100;
   localparam logic [4:0] OP_BR    = 5'b11000;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b11011;
   localparam logic [4:0] OP_JALR  = 5'b11001;

`ifdef IMM_RANGE_CHECK_EN
   localparam logic RANGE_CHK = 1'b1;
`else
   localparam logic RANGE_CHK = 1'b0;
`endif

   typedef struct packed {
      logic [XLEN-1:0]   instr;
      logic              illegal;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   entry_t            head_q, head_d, tail_q, tail_d, new_e;
   logic [1:0]        cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

   logic [XLEN-1:0] enc_c;
   logic            enc_ill_c, imm_ok_c, illegal_c;
   logic [2:0]      f3_c;
   logic            sext11_c, sext12_c, sext20_c;
   logic            push_c, pop_c;

   // Field assembly per opcode class; imm_ok_c records whether the immediate fits its format
   always_comb begin
      enc_c     = '0;
      enc_ill_c = 1'b0;
      imm_ok_c  = 1'b1;
      f3_c      = alu_op_i[2:0];
      sext11_c  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      sext12_c  = (&imm_i[31:12]) | ~(|imm_i[31:12]);
      sext20_c  = (&imm_i[31:20]) | ~(|imm_i[31:20]);
      case (opcode_i)
         OP_REG: begin
            enc_ill_c = alu_op_i[3] && !((f3_c == 3'b000) || (f3_c == 3'b101));
            enc_c = {1'b0, alu_op_i[3], 5'b0, rs2_i, rs1_i, f3_c, rd_i, opcode_i, 2'b11};
         end
         OP_IMM: begin
            enc_ill_c = alu_op_i[3] && (f3_c != 3'b101);
            if ((f3_c == 3'b001) || (f3_c == 3'b101)) begin
               enc_c    = {1'b0, alu_op_i[3], 5'b0, imm_i[4:0], rs1_i, f3_c, rd_i, opcode_i, 2'b11};
               imm_ok_c = (imm_i[11:5] == 7'd0);
            end else begin
               enc_c    = {imm_i[11:0], rs1_i, f3_c, rd_i, opcode_i, 2'b11};
               imm_ok_c = sext11_c;
            end
         end
         OP_LOAD, OP_JALR: begin
            enc_c    = {imm_i[11:0], rs1_i, mem_funct3_i, rd_i, opcode_i, 2'b11};
            imm_ok_c = sext11_c;
         end
         OP_STORE: begin
            enc_c    = {imm_i[11:5], rs2_i, rs1_i, mem_funct3_i, imm_i[4:0], opcode_i, 2'b11};
            imm_ok_c = sext11_c;
         end
         OP_BR: begin
            case (alu_op_i)
               4'b1001: f3_c = 3'b000;
               4'b1010: f3_c = 3'b001;
               4'b1011: f3_c = 3'b100;
               4'b1100: f3_c = 3'b101;
               4'b1110: f3_c = 3'b110;
               4'b1111: f3_c = 3'b111;
               default: enc_ill_c = 1'b1;
            endcase
            enc_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_c, imm_i[4:1], imm_i[11],
                     opcode_i, 2'b11};
            imm_ok_c = sext12_c && !imm_i[0];
         end
         OP_LUI, OP_AUIPC: begin
            enc_c    = {imm_i[31:12], rd_i, opcode_i, 2'b11};
            imm_ok_c = (imm_i[11:0] == 12'd0);
         end
         OP_JAL: begin
            enc_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i, 2'b11};
            imm_ok_c = sext20_c && !imm_i[0];
         end
         default: enc_ill_c = 1'b1;
      endcase
      illegal_c = enc_ill_c | (RANGE_CHK & ~imm_ok_c);
   end

   assign in_ready_o = ~cnt_q[1] & ~flush_i;
   assign push_c     = in_valid_i & in_ready_o;
   assign pop_c      = valid_q & out_ready_i;

   // Two-entry buffer: head drives the outputs, tail holds the second word
   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      addr_cnt_d    = addr_cnt_q;
      new_e.instr   = illegal_c ? NOP : enc_c;
      new_e.illegal = illegal_c;
      new_e.addr    = addr_cnt_q;
      if (flush_i) begin
         cnt_d      = 2'd0;
         err_d      = 1'b0;
         addr_cnt_d = BASE_ADDR;
      end else begin
         if (push_c) begin
            addr_cnt_d = addr_cnt_q + ADDR_W'(4);
            err_d      = err_q | illegal_c;
         end
         if (pop_c) begin
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
            end else if (push_c) begin
               head_d = new_e;
            end
         end else if (push_c) begin
            if (cnt_q == 2'd0) begin
               head_d = new_e;
            end else begin
               tail_d = new_e;
            end
         end
         if (push_c && !pop_c) begin
            cnt_d = cnt_q + 2'd1;
         end else if (pop_c && !push_c) begin
            cnt_d = cnt_q - 2'd1;
         end
      end
      valid_d = (cnt_d != 2'd0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= 2'd0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         addr_cnt_q <= BASE_ADDR;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         addr_cnt_q <= addr_cnt_d;
      end
   end

   assign out_valid_o  = valid_q;
   assign instr_o      = head_q.instr;
   assign addr_o       = head_q.addr;
   assign illegal_o    = head_q.illegal;
   assign err_sticky_o = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a scoreboard queue; a second instance checks 4-bit address wrap.
module tb_instr_encoder;

   logic        clk_i = 1'b0;
   logic        rst_ni, flush_i, in_valid_i, out_ready_i;
   logic [4:0]  opcode_i, rs1_i, rs2_i, rd_i;
   logic [3:0]  alu_op_i;
   logic [2:0]  mem_funct3_i;
   logic [31:0] imm_i;
   logic        in_ready_o, out_valid_o, illegal_o, err_sticky_o;
   logic [31:0] instr_o, addr_o;
   logic        w_in_ready, w_out_valid, w_illegal, w_err;
   logic [31:0] w_instr;
   logic [3:0]  w_addr;

   typedef struct {
      logic [31:0] instr;
      logic        ill;
      logic [31:0] addr;
      logic [3:0]  addr4;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ea;
   logic [3:0]  ea4;
   logic [31:0] cur_instr;
   logic        cur_ill;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk_i = ~clk_i;

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .opcode_i(opcode_i), .alu_op_i(alu_op_i), .mem_funct3_i(mem_funct3_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .imm_i(imm_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .instr_o(instr_o), .addr_o(addr_o), .illegal_o(illegal_o), .err_sticky_o(err_sticky_o)
   );

   instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_w (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(w_in_ready),
      .opcode_i(opcode_i), .alu_op_i(alu_op_i), .mem_funct3_i(mem_funct3_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .imm_i(imm_i),
      .out_valid_o(w_out_valid), .out_ready_i(out_ready_i),
      .instr_o(w_instr), .addr_o(w_addr), .illegal_o(w_illegal), .err_sticky_o(w_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on output handshake
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         sb.delete();
         ea  = 32'h0;
         ea4 = 4'hC;
      end else if (flush_i) begin
         sb.delete();
         ea  = 32'h0;
         ea4 = 4'hC;
      end else begin
         if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", 32'(out_valid_o), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("instr", instr_o, e.instr);
               chk("illegal", 32'(illegal_o), 32'(e.ill));
               chk("addr", addr_o, e.addr);
               chk("wrap_addr", 32'(w_addr), 32'(e.addr4));
               chk("wrap_valid", 32'(w_out_valid), 32'd1);
            end
         end
         if (in_valid_i && in_ready_o) begin
            sb.push_back('{instr: cur_instr, ill: cur_ill, addr: ea, addr4: ea4});
            ea  = ea + 32'd4;
            ea4 = ea4 + 4'd4;
         end
      end
   end

   task automatic send(input logic [4:0] op, input logic [3:0] alu, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [31:0] exp_i, input logic exp_ill);
      logic done;
      done         = 1'b0;
      opcode_i     = op;
      alu_op_i     = alu;
      mem_funct3_i = f3;
      rs1_i        = rs1;
      rs2_i        = rs2;
      rd_i         = rd;
      imm_i        = imm;
      cur_instr    = exp_i;
      cur_ill      = exp_ill;
      in_valid_i   = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk_i);
         done = in_ready_o;
         @(posedge clk_i);
         #1;
      end
      in_valid_i = 1'b0;
      chk("accept", 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      opcode_i = '0; alu_op_i = '0; mem_funct3_i = '0;
      rs1_i = '0; rs2_i = '0; rd_i = '0; imm_i = '0;
      cur_instr = '0; cur_ill = 1'b0;
      idle(3);
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_addr", addr_o, 32'd0);
      chk("rst_illegal", 32'(illegal_o), 32'd0);
      chk("rst_sticky", 32'(err_sticky_o), 32'd0);
      rst_ni = 1'b1;
      idle(1);
      chk("rst_ready", 32'(in_ready_o), 32'd1);

      // Basic encodings, streaming with the consumer always ready
      send(5'b01100, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
      chk("latency_valid", 32'(out_valid_o), 32'd1);
      chk("latency_instr", instr_o, 32'h002081B3);
      send(5'b01100, 4'b1000, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h402081B3, 1'b0);
      send(5'b00100, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093, 1'b0);
      send(5'b11000, 4'b1001, 3'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00208463, 1'b0);
      send(5'b01101, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7, 1'b0);
      send(5'b11011, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd1, 32'd16, 32'h010000EF, 1'b0);
      send(5'b00100, 4'b1101, 3'd0, 5'd1, 5'd0, 5'd2, 32'd3, 32'h4030D113, 1'b0);
      send(5'b01000, 4'b0000, 3'd2, 5'd1, 5'd2, 5'd0, 32'd8, 32'h0020A423, 1'b0);
      idle(3);

      // Flush, then backpressure with a full buffer
      flush_i = 1'b1;
      idle(1);
      flush_i = 1'b0;
      out_ready_i = 1'b0;
      send(5'b01100, 4'b0000, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h00520333, 1'b0);
      send(5'b01100, 4'b0111, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h00527333, 1'b0);
      chk("full_ready", 32'(in_ready_o), 32'd0);
      chk("full_addr", addr_o, 32'h0);
      idle(2);
      chk("held_addr", addr_o, 32'h0);
      chk("held_instr", instr_o, 32'h00520333);
      out_ready_i = 1'b1;
      @(negedge clk_i);
      chk("pop_full_ready", 32'(in_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      send(5'b01100, 4'b0110, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h00526333, 1'b0);
      chk("third_addr", addr_o, 32'h8);
      idle(3);

      // Illegal entries become NOPs and set the sticky error
      send(5'b11000, 4'b0101, 3'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00000013, 1'b1);
      chk("sticky_set", 32'(err_sticky_o), 32'd1);
      send(5'b11111, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h00000013, 1'b1);
      send(5'b00100, 4'b1000, 3'd0, 5'd1, 5'd0, 5'd2, 32'd1, 32'h00000013, 1'b1);
      send(5'b01100, 4'b1010, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h00000013, 1'b1);
      send(5'b00000, 4'b0000, 3'd2, 5'd2, 5'd0, 5'd7, 32'hFFFFFFFC, 32'hFFC12383, 1'b0);
      idle(3);
      chk("sticky_hold", 32'(err_sticky_o), 32'd1);

      // Flush mid-stream drops the concurrent input and clears state
      out_ready_i = 1'b0;
      send(5'b01100, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
      flush_i = 1'b1;
      in_valid_i = 1'b1;
      @(negedge clk_i);
      chk("flush_ready", 32'(in_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      chk("flush_valid", 32'(out_valid_o), 32'd0);
      chk("flush_sticky", 32'(err_sticky_o), 32'd0);
      out_ready_i = 1'b1;
      send(5'b00100, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093, 1'b0);
      chk("post_flush_addr", addr_o, 32'h0);
      chk("post_flush_wrap", 32'(w_addr), 32'hC);
`ifdef IMM_RANGE_CHECK_EN
      send(5'b11000, 4'b1001, 3'd0, 5'd1, 5'd2, 5'd0, 32'd7, 32'h00000013, 1'b1);
`else
      send(5'b11000, 4'b1001, 3'd0, 5'd1, 5'd2, 5'd0, 32'd7, 32'h00208363, 1'b0);
`endif
      idle(3);

      // Async reset with a full buffer clears the output immediately
      out_ready_i = 1'b0;
      send(5'b01100, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
      send(5'b01100, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
      chk("pre_reset_valid", 32'(out_valid_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid_o), 32'd0);
      chk("async_instr", instr_o, 32'd0);
      idle(2);
      rst_ni = 1'b1;
      out_ready_i = 1'b1;
      idle(2);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the RV32I instruction decoder: accepts decoded fields (opcode class, 4-bit ALU op code, register indices, 32-bit immediate) and assembles the 32-bit RV32I instruction word.
- Tags each word with a sequential instruction-memory address.
- Sits between the test/program-loader front end and the IMEM write port.
- Uses a valid/ready input and output with a 2-entry output buffer.

Parameters:
- ADDR_W, 32, width of generated IMEM byte address.
- BASE_ADDR, 0, address assigned to the first word after reset/flush.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of buffer, address counter and sticky error.
- in_valid_i  in  1  input fields valid.
- in_ready_o  out  1  encoder can accept.
- opcode_i  in  5  instr[6:2] class: 00000 load, 01000 store, 00100 ALU-imm, 01100 ALU-reg, 11000 branch, 01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR.
- alu_op_i  in  4  ALU code in decoder encoding.
- mem_funct3_i  in  3  funct3 for load/store/JALR.
- rs1_i, rs2_i, rd_i  in  5 each  register indices.
- imm_i  in  32  immediate, already sign-extended.
- out_valid_o  out  1  word valid.
- out_ready_i  in  1  consumer accepts.
- instr_o  out  32  encoded word.
- addr_o  out  ADDR_W  IMEM address of instr_o.
- illegal_o  out  1  entry was illegal; instr_o is then NOP 0x00000013.
- err_sticky_o  out  1  set on any accepted illegal entry; cleared by reset/flush.

Behaviour:
- Reset (async, rst_ni=0): buffer empty, out_valid_o=0, instr_o=0, addr_o=0, illegal_o=0, err_sticky_o=0, address counter=BASE_ADDR. in_ready_o=1 after reset release.
- Accept when in_valid_i & in_ready_o. in_ready_o = (registered count < 2). A pop in the same cycle does not raise in_ready_o when full.
- Latency: a word accepted into an empty buffer is presented the next cycle. Pop on out_valid_o & out_ready_i. Push and pop in the same cycle keep the count unchanged; FIFO order is preserved.
- Address: each accepted entry captures the counter value, then the counter adds 4, wrapping modulo 2^ADDR_W. Illegal entries still consume an address.
- Encoding: instr[1:0]=11, instr[6:2]=opcode_i.
  - R-type, 01100: funct3=alu_op_i[2:0]. instr[30]=alu_op_i[3] only for funct3 000 or 101, else illegal if alu_op_i[3]=1.
  - I-type, 00100: same rule, except alu_op 1000 is illegal (there is no SUBI). Shifts put the shamt in imm[4:0] and instr[30]=alu_op_i[3] for funct3 101.
  - Load, JALR: I-format with funct3=mem_funct3_i.
  - Store: S-format with funct3=mem_funct3_i.
  - Branch: alu_op 1001/1010/1011/1100/1110/1111 map to funct3 000/001/100/101/110/111; any other alu_op is illegal. B-format from imm[12:1].
  - LUI, AUIPC: U-format from imm[31:12].
  - JAL: J-format from imm[20:1].
  - Any other opcode_i is illegal.
  - Fields unused by a format are zero.
- flush_i: buffer emptied, counter=BASE_ADDR, err_sticky_o=0. An input presented in the same cycle is dropped, because in_ready_o is forced 0 during flush.
- flush_i has priority over push/pop. Async reset has priority over everything.

Optional Feature:
- IMM_RANGE_CHECK_EN defined: an accepted entry is flagged illegal (NOP, illegal_o=1, sticky set) when the immediate does not fit its format:
  - I/S-type: not sign-extended from bit 11.
  - Branch: not sign-extended from bit 12, or imm[0]≠0.
  - JAL: not sign-extended from bit 20, or imm[0]≠0.
  - LUI/AUIPC: imm[11:0]≠0.
  - Shift-immediate: imm[11:5]≠0.
- Not defined: out-of-range bits are silently truncated to the format's fields.

Test Plan:
- ADD x3,x1,x2 (01100, alu 0000, rs1=1, rs2=2, rd=3) -> 0x002081B3, addr 0x0. Same with alu 1000 -> 0x402081B3, addr 0x4.
- ADDI x1,x0,5 -> 0x00500093. BEQ x1,x2,+8 (alu 1001) -> 0x00208463. LUI x5, imm 0x12345000 -> 0x123452B7. JAL x1,+16 -> 0x010000EF.
- Backpressure: out_ready_i=0, push 3 entries -> in_ready_o=0 after 2, addresses 0x0/0x4 held. Release out_ready_i -> FIFO order preserved, third entry gets 0x8.
- Illegal: branch with alu 0101 -> instr_o 0x00000013, illegal_o=1, err_sticky_o=1 until flush_i.
- Wrap and flush: ADDR_W=4, BASE_ADDR=0xC -> addresses 0xC then 0x0. flush_i mid-stream -> out_valid_o=0 next cycle, next word at 0xC.
- Async reset asserted with a full buffer -> out_valid_o=0 immediately. With IMM_RANGE_CHECK_EN, BEQ imm=7 -> illegal_o=1.
